gc_poll_scheduler: RTL and testbench

- Sequences the Joybus serial transceiver that drives the GameCube controller data line.
- After enable, probes the controller (cmd 0x00), then polls it periodically (cmd 0x40 0x03 rumble).
- Collects each 8-byte response into a pad-state register; tracks connection status with timeout and failure counting.
- Sits between the top-level Gamecube design and the bit-level transceiver; the transceiver owns line timing.

---
 rtl/gc_pkg.sv | 24 ++
 rtl/gc_resp_collector.sv | 53 +++++
 rtl/gc_poll_scheduler.sv | 179 +++++++++++++++++
 tb/tb_gc_poll_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared types and constants for the GameCube controller poll scheduler.
package gc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StProbeTx,
    StProbeRx,
    StWait,
    StPollTx,
    StPollRx
  } gc_sched_state_t;

  localparam logic [7:0] CMD_PROBE = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h40;
  localparam logic [7:0] POLL_MODE = 8'h03;

  localparam int unsigned PROBE_RESP_BYTES = 3;
  localparam int unsigned POLL_RESP_BYTES  = 8;

  // Byte counter saturates one past the longest legal reply so overlong replies still fail.
  localparam int unsigned RespCntSat = 9;
  localparam int unsigned RespCntW   = 4;

endpackage

// File: rtl/gc_resp_collector.sv
// Response collector: byte counter, 64-bit shift register and sticky error flag.
// Outputs are next-state values so a byte arriving alongside rx_done is already included.
module gc_resp_collector
  import gc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_i,
  input  logic                err_i,
  output logic [RespCntW-1:0] cnt_o,
  output logic [63:0]         data_o,
  output logic                err_o
);

  logic [RespCntW-1:0] cnt_q, cnt_d;
  logic [63:0]         data_q, data_d;
  logic                err_q, err_d;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    err_d  = err_q | err_i;
    if (clear_i) begin
      cnt_d  = '0;
      data_d = '0;
      err_d  = 1'b0;
    end else if (byte_valid_i) begin
      data_d = {data_q[55:0], byte_i};
      if (cnt_q != RespCntW'(RespCntSat)) begin
        cnt_d = cnt_q + RespCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign cnt_o  = cnt_d;
  assign data_o = data_d;
  assign err_o  = err_d;

endmodule

// File: rtl/gc_poll_scheduler.sv
// Joybus command sequencer: probes the controller, then polls it periodically and
// tracks connection health from the replies.
module gc_poll_scheduler
  import gc_pkg::*;
#(
  parameter int unsigned POLL_PERIOD_CYC  = 833_333,
  parameter int unsigned RESP_TIMEOUT_CYC = 25_000,
  parameter int unsigned MAX_FAIL         = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rumble,
  output logic        tx_start,
  output logic [1:0]  tx_len,
  output logic [23:0] tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  input  logic        rx_err,
  output logic [63:0] pad_state,
  output logic        pad_valid,
  output logic        connected,
  output logic [1:0]  fail_cnt
);

  localparam int unsigned TmrW = $clog2(POLL_PERIOD_CYC);
  // tx_start is registered, so leave WAIT two cycles early to keep launches exactly one period apart.
  localparam logic [TmrW-1:0] LaunchAt = TmrW'(POLL_PERIOD_CYC - 2);
  localparam logic [TmrW-1:0] TmoAt    = TmrW'(RESP_TIMEOUT_CYC - 1);
  localparam logic [1:0]      FailLast = 2'(MAX_FAIL - 1);

  gc_sched_state_t state_q, state_d;
  logic [TmrW-1:0] period_q, period_d;
  logic [TmrW-1:0] tmo_q, tmo_d;
  logic            tx_start_q, tx_start_d;
  logic [1:0]      tx_len_q, tx_len_d;
  logic [23:0]     tx_data_q, tx_data_d;
  logic [63:0]     pad_state_q, pad_state_d;
  logic            pad_valid_q, pad_valid_d;
  logic            connected_q, connected_d;
  logic [1:0]      fail_cnt_q, fail_cnt_d;

  logic                launch;
  logic                in_rx;
  logic                timed_out;
  logic [RespCntW-1:0] col_cnt;
  logic [63:0]         col_data;
  logic                col_err;

  assign in_rx     = (state_q == StProbeRx) || (state_q == StPollRx);
  assign timed_out = (tmo_q >= TmoAt);

  gc_resp_collector u_collector (
    .clk_i        (CLOCK_50),
    .rst_ni       (reset_n),
    .clear_i      (launch),
    .byte_valid_i (rx_valid & in_rx),
    .byte_i       (rx_byte),
    .err_i        (rx_err & in_rx),
    .cnt_o        (col_cnt),
    .data_o       (col_data),
    .err_o        (col_err)
  );

  always_comb begin
    state_d     = state_q;
    period_d    = (period_q == '1) ? period_q : period_q + TmrW'(1);
    tmo_d       = (tmo_q == '1) ? tmo_q : tmo_q + TmrW'(1);
    tx_start_d  = 1'b0;
    tx_len_d    = tx_len_q;
    tx_data_d   = tx_data_q;
    pad_state_d = pad_state_q;
    pad_valid_d = 1'b0;
    connected_d = connected_q;
    fail_cnt_d  = fail_cnt_q;
    launch      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StProbeTx;
      end
      StProbeTx: begin
        if (!tx_busy) begin
          launch    = 1'b1;
          tx_len_d  = 2'd1;
          tx_data_d = {CMD_PROBE, 16'h0000};
          state_d   = StProbeRx;
        end
      end
      StPollTx: begin
        if (!tx_busy) begin
          launch    = 1'b1;
          tx_len_d  = 2'd3;
          tx_data_d = {CMD_POLL, POLL_MODE, 7'b0, rumble};
          state_d   = StPollRx;
        end
      end
      StProbeRx: begin
        if (rx_done) begin
          if (col_cnt == RespCntW'(PROBE_RESP_BYTES) && !col_err) begin
            connected_d = 1'b1;
            fail_cnt_d  = 2'd0;
          end
          state_d = StWait;
        end else if (timed_out) begin
          state_d = StWait;
        end
      end
      StPollRx: begin
        if (rx_done && col_cnt == RespCntW'(POLL_RESP_BYTES) && !col_err) begin
          pad_state_d = col_data;
          pad_valid_d = 1'b1;
          fail_cnt_d  = 2'd0;
          state_d     = StWait;
        end else if (rx_done || timed_out) begin
          if (fail_cnt_q == FailLast) begin
            connected_d = 1'b0;
            fail_cnt_d  = 2'd0;
            pad_state_d = '0;
          end else begin
            fail_cnt_d = fail_cnt_q + 2'd1;
          end
          state_d = StWait;
        end
      end
      StWait: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (period_q >= LaunchAt) begin
          state_d = connected_q ? StPollTx : StProbeTx;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      tx_start_d = 1'b1;
      period_d   = '0;
      tmo_d      = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      period_q    <= '0;
      tmo_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_len_q    <= 2'd0;
      tx_data_q   <= '0;
      pad_state_q <= '0;
      pad_valid_q <= 1'b0;
      connected_q <= 1'b0;
      fail_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      tmo_q       <= tmo_d;
      tx_start_q  <= tx_start_d;
      tx_len_q    <= tx_len_d;
      tx_data_q   <= tx_data_d;
      pad_state_q <= pad_state_d;
      pad_valid_q <= pad_valid_d;
      connected_q <= connected_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_len    = tx_len_q;
  assign tx_data   = tx_data_q;
  assign pad_state = pad_state_q;
  assign pad_valid = pad_valid_q;
  assign connected = connected_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// Directed bench for gc_poll_scheduler with short poll period and timeout.
module tb_gc_poll_scheduler;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        rumble;
  logic        tx_start;
  logic [1:0]  tx_len;
  logic [23:0] tx_data;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        rx_err;
  logic [63:0] pad_state;
  logic        pad_valid;
  logic        connected;
  logic [1:0]  fail_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  gc_poll_scheduler #(
    .POLL_PERIOD_CYC  (2000),
    .RESP_TIMEOUT_CYC (500),
    .MAX_FAIL         (3)
  ) dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .rumble    (rumble),
    .tx_start  (tx_start),
    .tx_len    (tx_len),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .pad_state (pad_state),
    .pad_valid (pad_valid),
    .connected (connected),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err, input logic done);
    rx_valid = 1'b1;
    rx_byte  = b;
    rx_err   = err;
    rx_done  = done;
    step();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rx_err   = 1'b0;
    rx_done  = 1'b0;
  endtask

  task automatic send_done();
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic wait_tx(input int limit, output int at, output logic found);
    found = 1'b0;
    at    = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (tx_start === 1'b1) begin
        found = 1'b1;
        at    = cyc;
        break;
      end
    end
  endtask

  initial begin
    #(60000 * 20);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [7:0] poll_a [8];
  logic [7:0] poll_b [8];
  logic [63:0] pad_exp;
  int   t_prev, t_now, hits;
  logic found;

  initial begin
    poll_a = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
    poll_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    reset_n = 1'b0; enable = 1'b0; rumble = 1'b0; tx_busy = 1'b0;
    rx_valid = 1'b0; rx_byte = 8'h00; rx_done = 1'b0; rx_err = 1'b0;
    repeat (50) step();
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_len", tx_len, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_pad_state", pad_state, 0);
    check_eq("rst_pad_valid", pad_valid, 0);
    check_eq("rst_connected", connected, 0);
    check_eq("rst_fail_cnt", fail_cnt, 0);

    reset_n = 1'b1;
    step();
    enable = 1'b1;
    step();
    check_eq("probe_not_yet", tx_start, 0);
    step();
    check_eq("probe_tx_start", tx_start, 1);
    check_eq("probe_tx_len", tx_len, 1);
    check_eq("probe_tx_data", tx_data, 0);
    check_eq("probe_conn0", connected, 0);
    t_prev = cyc;

    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_done();
    check_eq("probe_connected", connected, 1);
    check_eq("probe_fail_cnt", fail_cnt, 0);

    wait_tx(2500, t_now, found);
    check_eq("poll1_seen", found, 1);
    check_eq("poll1_period", 64'(t_now - t_prev), 2000);
    check_eq("poll1_tx_len", tx_len, 3);
    check_eq("poll1_tx_data", tx_data, 24'h400300);
    t_prev = t_now;

    // Last byte arrives together with rx_done.
    for (int i = 0; i < 8; i++) send_byte(poll_a[i], 1'b0, i == 7);
    pad_exp = 64'h0080808080800000;
    check_eq("poll1_pad_valid", pad_valid, 1);
    check_eq("poll1_pad_state", pad_state, pad_exp);
    check_eq("poll1_fail_cnt", fail_cnt, 0);
    step();
    check_eq("poll1_pad_valid_pulse", pad_valid, 0);

    // Reply traffic while in WAIT must be ignored.
    send_byte(8'hFF, 1'b0, 1'b1);
    step();
    check_eq("wait_rx_ignored_valid", pad_valid, 0);
    check_eq("wait_rx_ignored_pad", pad_state, pad_exp);
    check_eq("wait_rx_ignored_conn", connected, 1);

    rumble = 1'b1;
    wait_tx(2500, t_now, found);
    check_eq("poll2_seen", found, 1);
    check_eq("poll2_period", 64'(t_now - t_prev), 2000);
    check_eq("poll2_tx_data_rumble", tx_data, 24'h400301);
    rumble = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(poll_b[i], 1'b0, 1'b0);
    send_done();
    check_eq("short_fail_cnt", fail_cnt, 1);
    check_eq("short_pad_valid", pad_valid, 0);
    check_eq("short_pad_state", pad_state, pad_exp);
    check_eq("short_connected", connected, 1);

    wait_tx(2500, t_now, found);
    check_eq("poll3_seen", found, 1);
    check_eq("poll3_tx_data", tx_data, 24'h400300);
    for (int i = 0; i < 8; i++) send_byte(poll_b[i], i == 3, i == 7);
    check_eq("err_fail_cnt", fail_cnt, 2);
    check_eq("err_pad_valid", pad_valid, 0);
    check_eq("err_pad_state", pad_state, pad_exp);

    wait_tx(2500, t_now, found);
    check_eq("poll4_seen", found, 1);
    for (int i = 0; i < 8; i++) send_byte(poll_b[i], 1'b0, i == 7);
    check_eq("poll4_pad_valid", pad_valid, 1);
    check_eq("poll4_pad_state", pad_state, 64'h0102030405060708);
    check_eq("poll4_fail_cnt", fail_cnt, 0);

    for (int k = 0; k < 3; k++) begin
      wait_tx(2500, t_now, found);
      check_eq("silent_poll_seen", found, 1);
      check_eq("silent_poll_len", tx_len, 3);
      repeat (520) step();
      check_eq("silent_fail_cnt", fail_cnt, (k == 2) ? 0 : k + 1);
      check_eq("silent_connected", connected, (k == 2) ? 0 : 1);
    end
    check_eq("disc_pad_state", pad_state, 0);

    wait_tx(2500, t_now, found);
    check_eq("reprobe_seen", found, 1);
    check_eq("reprobe_tx_len", tx_len, 1);
    check_eq("reprobe_tx_data", tx_data, 0);
    t_prev = t_now;
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1 ^ 1'b1, 1'b1);
    check_eq("reprobe_connected", connected, 1);

    tx_busy = 1'b1;
    hits = 0;
    while (cyc < t_prev + 2100) begin
      step();
      if (tx_start === 1'b1) hits++;
    end
    check_eq("busy_no_tx_start", hits, 0);
    tx_busy = 1'b0;
    step();
    check_eq("busy_release_tx_start", tx_start, 1);
    check_eq("busy_release_tx_len", tx_len, 3);

    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    reset_n = 1'b0;
    step();
    check_eq("midrx_rst_tx_start", tx_start, 0);
    check_eq("midrx_rst_tx_len", tx_len, 0);
    check_eq("midrx_rst_tx_data", tx_data, 0);
    check_eq("midrx_rst_pad_state", pad_state, 0);
    check_eq("midrx_rst_connected", connected, 0);
    check_eq("midrx_rst_fail_cnt", fail_cnt, 0);
    reset_n = 1'b1;
    step();
    check_eq("post_rst_quiet", tx_start, 0);
    step();
    check_eq("post_rst_probe", tx_start, 1);
    check_eq("post_rst_probe_len", tx_len, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
